// File: rtl/tri_inside_collect.sv
// -----------------------------------------------------------------------------
// tri_inside_collect
//
// Downstream stage of the signP edge-sign unit. Gathers three edge-sign bits
// per test point, declares the point inside the triangle when all three signs
// agree, and queues {index, inside} results in a small registered FIFO with a
// valid/ready output. It also keeps a saturating count of inside points and a
// sticky flag that records a result dropped on a full FIFO.
//
// Parameters
//   DEPTH  result FIFO entries (power of 2, >= 2)
//   IDX_W  width of the point index counter
//   CNT_W  width of the inside counter
//
// Ports
//   clk         rising-edge clock
//   r_n         asynchronous active-low reset
//   clr         synchronous clear, same effect as reset, wins over all inputs
//   s_valid     one-cycle strobe: s carries one edge sign
//   s           edge sign from signP
//   o_valid     FIFO head holds a result
//   o_ready     consumer accepts the head when o_valid & o_ready
//   o_inside    head result: 1 = all three signs equal
//   o_idx       head result: point index
//   inside_cnt  number of accepted inside points, saturating
//   ovf         sticky: a result was dropped because the FIFO was full
// -----------------------------------------------------------------------------
module tri_inside_collect #(
    parameter int DEPTH = 4,
    parameter int IDX_W = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             r_n,
    input  logic             clr,
    input  logic             s_valid,
    input  logic             s,
    output logic             o_valid,
    input  logic             o_ready,
    output logic             o_inside,
    output logic [IDX_W-1:0] o_idx,
    output logic [CNT_W-1:0] inside_cnt,
    output logic             ovf
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam int ENT_W = IDX_W + 1;

    localparam logic [1:0] E0 = 2'd0;
    localparam logic [1:0] E1 = 2'd1;
    localparam logic [1:0] E2 = 2'd2;

    localparam logic [OCC_W-1:0] OCC_FULL  = OCC_W'(DEPTH);
    localparam logic [OCC_W-1:0] OCC_EMPTY = OCC_W'(0);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

    logic [1:0]       state_r;
    logic [1:0]       state_nxt_s;
    logic             sg0_r;
    logic             sg1_r;
    logic [IDX_W-1:0] idx_r;

    logic [ENT_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] rd_ptr_nxt_s;
    logic [OCC_W-1:0] occ_r;
    logic [OCC_W-1:0] occ_nxt_s;

    logic [ENT_W-1:0] head_r;
    logic [ENT_W-1:0] head_nxt_s;
    logic [ENT_W-1:0] new_ent_s;
    logic             o_valid_r;
    logic [CNT_W-1:0] cnt_r;
    logic             ovf_r;

    logic triple_s;
    logic inside_s;
    logic full_s;
    logic pop_s;
    logic push_ok_s;
    logic drop_s;

    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign triple_s  = s_valid && (state_r == E2);
    assign inside_s  = (sg0_r == sg1_r) && (sg1_r == s);
    assign full_s    = (occ_r == OCC_FULL);
    assign pop_s     = (occ_r != OCC_EMPTY) && o_ready;
    assign push_ok_s = triple_s && (!full_s || pop_s);
    assign drop_s    = triple_s && full_s && !pop_s;
    assign new_ent_s = {idx_r, inside_s};

    // Collector FSM next state: advance one step per edge sign.
    always_comb begin
        state_nxt_s = state_r;
        if (s_valid) begin
            case (state_r)
                E0:      state_nxt_s = E1;
                E1:      state_nxt_s = E2;
                E2:      state_nxt_s = E0;
                default: state_nxt_s = E0;
            endcase
        end else begin
            state_nxt_s = state_r;
        end
    end

    // Occupancy after this cycle's push/pop.
    always_comb begin
        occ_nxt_s = occ_r;
        case ({push_ok_s, pop_s})
            2'b10:   occ_nxt_s = occ_r + OCC_W'(1);
            2'b01:   occ_nxt_s = occ_r - OCC_W'(1);
            default: occ_nxt_s = occ_r;
        endcase
    end

    // Next head entry; a push landing directly in the head slot is forwarded
    // so the registered head outputs see it one cycle after the third sign.
    always_comb begin
        rd_ptr_nxt_s = rd_ptr_r;
        head_nxt_s   = mem_r[rd_ptr_r];
        if (pop_s) begin
            rd_ptr_nxt_s = rd_ptr_r + PTR_W'(1);
        end else begin
            rd_ptr_nxt_s = rd_ptr_r;
        end
        if (push_ok_s && (wr_ptr_r == rd_ptr_nxt_s)) begin
            head_nxt_s = new_ent_s;
        end else begin
            head_nxt_s = mem_r[rd_ptr_nxt_s];
        end
    end

    // Collector state, stored signs and point index.
    always_ff @(posedge clk or negedge r_n) begin
        if (!r_n) begin
            state_r <= E0;
            sg0_r   <= 1'b0;
            sg1_r   <= 1'b0;
            idx_r   <= '0;
        end else if (clr) begin
            state_r <= E0;
            sg0_r   <= 1'b0;
            sg1_r   <= 1'b0;
            idx_r   <= '0;
        end else begin
            state_r <= state_nxt_s;
            if (s_valid && (state_r == E0)) begin
                sg0_r <= s;
            end
            if (s_valid && (state_r == E1)) begin
                sg1_r <= s;
            end
            // Index advances even on a dropped push, leaving a visible gap.
            if (triple_s) begin
                idx_r <= idx_r + IDX_W'(1);
            end
        end
    end

    // FIFO storage, pointers, occupancy and registered head outputs.
    always_ff @(posedge clk or negedge r_n) begin
        if (!r_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r  <= '0;
            rd_ptr_r  <= '0;
            occ_r     <= '0;
            head_r    <= '0;
            o_valid_r <= 1'b0;
        end else if (clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r  <= '0;
            rd_ptr_r  <= '0;
            occ_r     <= '0;
            head_r    <= '0;
            o_valid_r <= 1'b0;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= new_ent_s;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
            end
            rd_ptr_r  <= rd_ptr_nxt_s;
            occ_r     <= occ_nxt_s;
            head_r    <= head_nxt_s;
            o_valid_r <= (occ_nxt_s != OCC_EMPTY);
        end
    end

    // Saturating inside counter and sticky overflow flag.
    always_ff @(posedge clk or negedge r_n) begin
        if (!r_n) begin
            cnt_r <= '0;
            ovf_r <= 1'b0;
        end else if (clr) begin
            cnt_r <= '0;
            ovf_r <= 1'b0;
        end else begin
            if (push_ok_s && inside_s && (cnt_r != CNT_MAX)) begin
                cnt_r <= cnt_r + CNT_W'(1);
            end
            if (drop_s) begin
                ovf_r <= 1'b1;
            end
        end
    end

    assign o_valid    = o_valid_r;
    assign o_inside   = head_r[0];
    assign o_idx      = head_r[ENT_W-1:1];
    assign inside_cnt = cnt_r;
    assign ovf        = ovf_r;

endmodule

// File: tb/tb_tri_inside_collect.sv
module tb_tri_inside_collect;

    localparam int DEPTH   = 4;
    localparam int IDX_W   = 8;
    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             r_n = 1'b0;
    logic             clr = 1'b0;
    logic             s_valid = 1'b0;
    logic             s = 1'b0;
    logic             o_valid;
    logic             o_ready = 1'b0;
    logic             o_inside;
    logic [IDX_W-1:0] o_idx;
    logic [CNT_W-1:0] inside_cnt;
    logic             ovf;

    // Narrow-counter instance for index wrap and counter saturation.
    logic       clr2 = 1'b0;
    logic       sv2 = 1'b0;
    logic       s2 = 1'b0;
    logic       rdy2 = 1'b0;
    logic       ov2;
    logic       oi2;
    logic [1:0] oidx2;
    logic [1:0] cnt2;
    logic       ovf2;

    int checks = 0;
    int failures = 0;

    // Reference model state
    int mq[$];      // entries encoded idx*2 + inside
    bit msg[$];     // partial sign triple
    int midx;
    int mcnt;
    bit movf;

    always #5 clk = ~clk;

    tri_inside_collect #(.DEPTH(DEPTH), .IDX_W(IDX_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .r_n(r_n), .clr(clr), .s_valid(s_valid), .s(s),
        .o_valid(o_valid), .o_ready(o_ready), .o_inside(o_inside),
        .o_idx(o_idx), .inside_cnt(inside_cnt), .ovf(ovf)
    );

    tri_inside_collect #(.DEPTH(4), .IDX_W(2), .CNT_W(2)) dut2 (
        .clk(clk), .r_n(r_n), .clr(clr2), .s_valid(sv2), .s(s2),
        .o_valid(ov2), .o_ready(rdy2), .o_inside(oi2),
        .o_idx(oidx2), .inside_cnt(cnt2), .ovf(ovf2)
    );

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        msg.delete();
        midx = 0;
        mcnt = 0;
        movf = 1'b0;
    endtask

    // One clock of the behavioural model, using this cycle's inputs.
    task automatic model_step(input bit c, input bit sv, input bit sb, input bit rdy);
        bit pop;
        bit ins;
        if (c) begin
            model_reset();
            return;
        end
        pop = (mq.size() > 0) && rdy;
        if (pop) void'(mq.pop_front());
        if (sv) begin
            msg.push_back(sb);
            if (msg.size() == 3) begin
                ins = (msg[0] == msg[1]) && (msg[1] == msg[2]);
                if (mq.size() < DEPTH) begin
                    mq.push_back(midx * 2 + int'(ins));
                    if (ins && mcnt < CNT_MAX) mcnt++;
                end else begin
                    movf = 1'b1;
                end
                midx = (midx + 1) % (1 << IDX_W);
                msg.delete();
            end
        end
    endtask

    // Apply inputs for one cycle; returns at the following negedge.
    task automatic cycle(input bit c, input bit sv, input bit sb, input bit rdy);
        clr = c; s_valid = sv; s = sb; o_ready = rdy;
        model_step(c, sv, sb, rdy);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic cycle2(input bit c, input bit sv, input bit sb, input bit rdy);
        clr2 = c; sv2 = sv; s2 = sb; rdy2 = rdy;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic compare_model(input string tag);
        check({tag, "_valid"}, int'(o_valid), int'(mq.size() > 0));
        if (mq.size() > 0) begin
            check({tag, "_idx"}, int'(o_idx), mq[0] / 2);
            check({tag, "_inside"}, int'(o_inside), mq[0] % 2);
        end
        check({tag, "_cnt"}, int'(inside_cnt), mcnt);
        check({tag, "_ovf"}, int'(ovf), int'(movf));
    endtask

    typedef struct {
        bit c; bit sv; bit sb; bit rdy;
        bit ev; bit ei; int eidx; int ecnt; bit eovf;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit c, bit sv, bit sb, bit rdy,
                                bit ev, bit ei, int eidx, int ecnt, bit eovf);
        vec_t v;
        v.c = c; v.sv = sv; v.sb = sb; v.rdy = rdy;
        v.ev = ev; v.ei = ei; v.eidx = eidx; v.ecnt = ecnt; v.eovf = eovf;
        return v;
    endfunction

    initial begin
        int n;
        // Signs 1,1,1 then 0,0,0 with o_ready=1
        tbl.push_back(mk(0,1,1,1, 0,0,0,0,0));
        tbl.push_back(mk(0,1,1,1, 0,0,0,0,0));
        tbl.push_back(mk(0,1,1,1, 1,1,0,1,0));
        tbl.push_back(mk(0,1,0,1, 0,0,0,1,0));
        tbl.push_back(mk(0,1,0,1, 0,0,0,1,0));
        tbl.push_back(mk(0,1,0,1, 1,1,1,2,0));
        tbl.push_back(mk(0,0,0,1, 0,0,0,2,0));
        // clr wins over a simultaneous sign
        tbl.push_back(mk(1,1,1,1, 0,0,0,0,0));
        // Signs 1,(idle),0,1 -> outside idx0; then 0,1,1 -> outside idx1
        tbl.push_back(mk(0,1,1,1, 0,0,0,0,0));
        tbl.push_back(mk(0,0,0,1, 0,0,0,0,0));
        tbl.push_back(mk(0,1,0,1, 0,0,0,0,0));
        tbl.push_back(mk(0,1,1,1, 1,0,0,0,0));
        tbl.push_back(mk(0,1,0,1, 0,0,0,0,0));
        tbl.push_back(mk(0,1,1,1, 0,0,0,0,0));
        tbl.push_back(mk(0,1,1,1, 1,0,1,0,0));
        tbl.push_back(mk(0,0,0,1, 0,0,0,0,0));

        model_reset();
        repeat (3) @(negedge clk);
        check("reset_valid", int'(o_valid), 0);
        check("reset_idx", int'(o_idx), 0);
        check("reset_inside", int'(o_inside), 0);
        check("reset_cnt", int'(inside_cnt), 0);
        check("reset_ovf", int'(ovf), 0);
        r_n = 1'b1;
        @(negedge clk);

        // Table-driven vectors
        for (int i = 0; i < tbl.size(); i++) begin
            cycle(tbl[i].c, tbl[i].sv, tbl[i].sb, tbl[i].rdy);
            check($sformatf("tbl%0d_valid", i), int'(o_valid), int'(tbl[i].ev));
            if (tbl[i].ev) begin
                check($sformatf("tbl%0d_inside", i), int'(o_inside), int'(tbl[i].ei));
                check($sformatf("tbl%0d_idx", i), int'(o_idx), tbl[i].eidx);
            end
            check($sformatf("tbl%0d_cnt", i), int'(inside_cnt), tbl[i].ecnt);
            check($sformatf("tbl%0d_ovf", i), int'(ovf), int'(tbl[i].eovf));
        end

        // Overflow: 5 inside points with o_ready=0, then drain
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 15; i++) cycle(0, 1, 1, 0);
        check("t3_ovf", int'(ovf), 1);
        check("t3_cnt", int'(inside_cnt), 4);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("t3_valid%0d", k), int'(o_valid), 1);
            check($sformatf("t3_idx%0d", k), int'(o_idx), k);
            cycle(0, 0, 0, 1);
        end
        check("t3_empty", int'(o_valid), 0);
        check("t3_ovf_sticky", int'(ovf), 1);

        // Full FIFO with pop in the same cycle as a third sign
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 12; i++) cycle(0, 1, 1, 0);
        cycle(0, 1, 1, 0);
        cycle(0, 1, 1, 0);
        cycle(0, 1, 1, 1);
        check("t4_ovf", int'(ovf), 0);
        check("t4_cnt", int'(inside_cnt), 5);
        n = 0;
        while (o_valid && n < 10) begin
            check($sformatf("t4_idx%0d", n), int'(o_idx), n + 1);
            cycle(0, 0, 0, 1);
            n++;
        end
        check("t4_occ", n, 4);

        // Asynchronous reset mid-triple
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 1, 1, 0);
        check("t5_pre_valid", int'(o_valid), 1);
        check("t5_pre_cnt", int'(inside_cnt), 1);
        cycle(0, 1, 1, 0);
        cycle(0, 1, 1, 0);
        s_valid = 1'b0;
        #2 r_n = 1'b0;
        model_reset();
        #1;
        check("t5_async_valid", int'(o_valid), 0);
        check("t5_async_cnt", int'(inside_cnt), 0);
        check("t5_async_idx", int'(o_idx), 0);
        #1 r_n = 1'b1;
        cycle(0, 0, 0, 1);
        for (int i = 0; i < 3; i++) cycle(0, 1, 0, 1);
        check("t5_valid", int'(o_valid), 1);
        check("t5_idx", int'(o_idx), 0);
        check("t5_inside", int'(o_inside), 1);

        // Randomized stimulus against the model
        cycle(1, 0, 0, 0);
        for (int i = 0; i < 600; i++) begin
            cycle(($urandom_range(0, 63) == 0), ($urandom_range(0, 9) < 6),
                  1'($urandom_range(0, 1)), ($urandom_range(0, 3) < 2));
            compare_model($sformatf("rnd%0d", i));
        end

        // Narrow widths: index wrap and counter saturation
        clr = 1'b0; s_valid = 1'b0; o_ready = 1'b1;
        cycle2(1, 0, 0, 1);
        for (int p = 0; p < 5; p++) begin
            for (int e = 0; e < 3; e++) cycle2(0, 1, 1, 1);
            check($sformatf("t6_valid%0d", p), int'(ov2), 1);
            check($sformatf("t6_idx%0d", p), int'(oidx2), p % 4);
            check($sformatf("t6_cnt%0d", p), int'(cnt2), (p + 1 > 3) ? 3 : p + 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
